// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC result drain path.
//   ACC_W            packed accumulator width
//   prec_level_t     precision level encoding (FULL/HALF/QUARTER/ILLEGAL)
//   LANE_W_*/LANES_* lane width and lane count for each precision level
//   drain_state_t    drain FSM state encoding
//   last_lane()      index of the final lane for a precision level
package mac_pkg;

  localparam int unsigned ACC_W = 56;

  typedef enum logic [1:0] {
    FULL    = 2'b00,
    HALF    = 2'b01,
    QUARTER = 2'b10,
    ILLEGAL = 2'b11
  } prec_level_t;

  localparam int unsigned LANE_W_FULL    = 56;
  localparam int unsigned LANE_W_HALF    = 28;
  localparam int unsigned LANE_W_QUARTER = 14;

  localparam int unsigned LANES_FULL    = 1;
  localparam int unsigned LANES_HALF    = 2;
  localparam int unsigned LANES_QUARTER = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMIT  = 2'd1,
    S_CLEAR = 2'd2
  } drain_state_t;

  function automatic logic [1:0] last_lane(input prec_level_t p);
    logic [1:0] r;
    unique case (p)
      HALF:    r = 2'(LANES_HALF - 1);
      QUARTER: r = 2'(LANES_QUARTER - 1);
      default: r = 2'(LANES_FULL - 1);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lane_requant.sv
// lane_requant: combinational extract / sign-extend / shift / saturate of
// one lane of the packed accumulator word.
//   word_i   packed accumulator word
//   prec_i   precision level selecting the lane layout
//   lane_i   lane index to extract
//   shamt_i  arithmetic right-shift amount
//   data_o   saturated OUT_W-bit signed result
// Build option: MAC_DRAIN_ROUND_EN adds 2^(shamt-1) before the shift
// (round half up); undefined gives a plain floor shift.
module lane_requant
  import mac_pkg::*;
#(
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 6
) (
  input  logic [ACC_W-1:0]   word_i,
  input  prec_level_t        prec_i,
  input  logic [1:0]         lane_i,
  input  logic [SHIFT_W-1:0] shamt_i,
  output logic [OUT_W-1:0]   data_o
);

  // One guard bit above the widest lane keeps the rounding add from wrapping.
  localparam int unsigned EXT_W = ACC_W + 1;
  localparam int unsigned CMP_W = (SHIFT_W > 7) ? SHIFT_W : 7;

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    $signed({{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [EXT_W-1:0] lane_ext;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;
  logic [CMP_W-1:0]        lane_w;
  logic [CMP_W-1:0]        shamt_x;

  always_comb begin
    lane_ext = EXT_W'($signed(word_i));
    lane_w   = CMP_W'(LANE_W_FULL);
    unique case (prec_i)
      HALF: begin
        lane_w = CMP_W'(LANE_W_HALF);
        if (lane_i[0]) lane_ext = EXT_W'($signed(word_i[55:28]));
        else           lane_ext = EXT_W'($signed(word_i[27:0]));
      end
      QUARTER: begin
        lane_w = CMP_W'(LANE_W_QUARTER);
        unique case (lane_i)
          2'd0:    lane_ext = EXT_W'($signed(word_i[13:0]));
          2'd1:    lane_ext = EXT_W'($signed(word_i[27:14]));
          2'd2:    lane_ext = EXT_W'($signed(word_i[41:28]));
          default: lane_ext = EXT_W'($signed(word_i[55:42]));
        endcase
      end
      default: begin
        lane_ext = EXT_W'($signed(word_i));
        lane_w   = CMP_W'(LANE_W_FULL);
      end
    endcase
  end

  always_comb begin
    shamt_x = CMP_W'(shamt_i);
    rounded = lane_ext;
    shifted = '0;
    if (shamt_x >= lane_w) begin
      // Everything shifted out: only the sign survives.
      shifted = lane_ext[EXT_W-1] ? '1 : '0;
    end else begin
`ifdef MAC_DRAIN_ROUND_EN
      if (shamt_x != '0)
        rounded = lane_ext + (EXT_W'(1) << (shamt_x - CMP_W'(1)));
`endif
      shifted = rounded >>> shamt_i;
    end
  end

  always_comb begin
    data_o = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX)      data_o = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) data_o = SAT_MIN[OUT_W-1:0];
  end

endmodule

// File: rtl/mac_result_drain.sv
// mac_result_drain: captures a packed accumulator word, streams its 1/2/4
// requantized lanes over valid/ready, then pulses a clear to the MAC.
//   clk, rstn              clock, asynchronous active-low reset
//   start                  request to drain acc_in (ignored while busy)
//   prec_level             lane layout (00 full, 01 half, 10 quarter, 11 illegal)
//   acc_in, shamt          accumulator word and right-shift amount
//   busy                   drain in progress
//   out_data/lane/last     registered output beat
//   out_valid, out_ready   beat handshake
//   mac_clr                one-cycle clear request after the final lane
//   err                    one-cycle pulse for start with an illegal level
// Build option: MAC_DRAIN_ROUND_EN enables round-half-up in lane_requant.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 6
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [1:0]         prec_level,
  input  logic [ACC_W-1:0]   acc_in,
  input  logic [SHIFT_W-1:0] shamt,
  output logic               busy,
  output logic [OUT_W-1:0]   out_data,
  output logic [1:0]         out_lane,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               mac_clr,
  output logic               err
);

  drain_state_t       state_q, state_d;
  logic [ACC_W-1:0]   word_q, word_d;
  prec_level_t        prec_q, prec_d;
  logic [SHIFT_W-1:0] shamt_q, shamt_d;
  logic [1:0]         lane_q, lane_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               last_q, last_d;
  logic               err_q, err_d;

  prec_level_t        prec_in;
  logic [ACC_W-1:0]   rq_word;
  prec_level_t        rq_prec;
  logic [1:0]         rq_lane;
  logic [SHIFT_W-1:0] rq_shamt;
  logic [OUT_W-1:0]   rq_data;

  assign prec_in = prec_level_t'(prec_level);

  // The requantizer always computes the *next* beat: lane 0 of the incoming
  // word while idle, lane_q+1 of the captured word while emitting. This lets
  // the beat be registered on the same edge as capture/handshake.
  always_comb begin
    rq_word  = word_q;
    rq_prec  = prec_q;
    rq_shamt = shamt_q;
    rq_lane  = lane_q + 2'd1;
    if (state_q == S_IDLE) begin
      rq_word  = acc_in;
      rq_prec  = prec_in;
      rq_shamt = shamt;
      rq_lane  = '0;
    end
  end

  lane_requant #(
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .word_i  (rq_word),
    .prec_i  (rq_prec),
    .lane_i  (rq_lane),
    .shamt_i (rq_shamt),
    .data_o  (rq_data)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    prec_d  = prec_q;
    shamt_d = shamt_q;
    lane_d  = lane_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (prec_in == ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            state_d = S_EMIT;
            word_d  = acc_in;
            prec_d  = prec_in;
            shamt_d = shamt;
            lane_d  = '0;
            data_d  = rq_data;
            last_d  = (last_lane(prec_in) == 2'd0);
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = S_CLEAR;
          end else begin
            lane_d = lane_q + 2'd1;
            data_d = rq_data;
            last_d = ((lane_q + 2'd1) == last_lane(prec_q));
          end
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      prec_q  <= FULL;
      shamt_q <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      prec_q  <= prec_d;
      shamt_q <= shamt_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_EMIT);
  assign mac_clr   = (state_q == S_CLEAR);
  assign out_data  = data_q;
  assign out_lane  = lane_q;
  assign out_last  = last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;
  import mac_pkg::*;

  localparam int unsigned OUT_W   = 8;
  localparam int unsigned SHIFT_W = 6;
  localparam longint SMAX = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (OUT_W - 1));

  logic               clk = 1'b0;
  logic               rstn, start, out_ready;
  logic [1:0]         prec_level;
  logic [ACC_W-1:0]   acc_in;
  logic [SHIFT_W-1:0] shamt;
  logic               busy, out_last, out_valid, mac_clr, err;
  logic [OUT_W-1:0]   out_data;
  logic [1:0]         out_lane;

  typedef struct {
    longint data;
    longint lane;
    longint last;
  } beat_t;

  beat_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mac_result_drain #(
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .prec_level (prec_level),
    .acc_in     (acc_in),
    .shamt      (shamt),
    .busy       (busy),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mac_clr    (mac_clr),
    .err        (err)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model(input longint v, input int w, input int sh);
    longint r;
    if (sh >= w) return (v < 0) ? -1 : 0;
    r = v;
`ifdef MAC_DRAIN_ROUND_EN
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
`endif
    r = r >>> sh;
    if (r > SMAX) return SMAX;
    if (r < SMIN) return SMIN;
    return r;
  endfunction

  function automatic logic [ACC_W-1:0] pack(input int p, input longint l0,
      input longint l1, input longint l2, input longint l3);
    logic [63:0] t0, t1, t2, t3;
    t0 = l0; t1 = l1; t2 = l2; t3 = l3;
    if (p == 0) return t0[55:0];
    if (p == 1) return {t1[27:0], t0[27:0]};
    return {t3[13:0], t2[13:0], t1[13:0], t0[13:0]};
  endfunction

  // Drains one word; 'stall' holds out_ready low for the first N beat cycles,
  // 'poke' drives a competing start during those stall cycles.
  task automatic run_drain(input int p, input longint l0, input longint l1,
      input longint l2, input longint l3, input int sh, input int stall,
      input bit poke);
    longint lv[4];
    int n, w, stalls, budget;
    beat_t b;
    logic [ACC_W-1:0] word;
    lv[0] = l0; lv[1] = l1; lv[2] = l2; lv[3] = l3;
    n = (p == 0) ? 1 : (p == 1) ? 2 : 4;
    w = (p == 0) ? 56 : (p == 1) ? 28 : 14;
    for (int k = 0; k < n; k++)
      sb.push_back('{model(lv[k], w, sh), longint'(k), longint'(k == n - 1)});
    word       = pack(p, l0, l1, l2, l3);
    start      = 1'b1;
    prec_level = 2'(p);
    acc_in     = word;
    shamt      = SHIFT_W'(sh);
    out_ready  = 1'b0;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    stalls = stall;
    budget = 0;
    while (sb.size() > 0 && budget < 64) begin
      check("valid", out_valid, 1);
      if (stalls > 0) begin
        out_ready = 1'b0;
        check("stall_hold_data", $signed(out_data), sb[0].data);
        check("stall_hold_lane", out_lane, sb[0].lane);
        stalls--;
        if (poke) begin
          start      = 1'b1;
          prec_level = 2'(QUARTER);
          acc_in     = ~word;
        end
      end else begin
        start     = 1'b0;
        out_ready = 1'b1;
        b = sb.pop_front();
        check("data", $signed(out_data), b.data);
        check("lane", out_lane, b.lane);
        check("last", out_last, b.last);
      end
      tick();
      budget++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check("mac_clr_pulse", mac_clr, 1);
    check("busy_in_clear", busy, 1);
    check("valid_in_clear", out_valid, 0);
    tick();
    check("mac_clr_once", mac_clr, 0);
    check("busy_fall", busy, 0);
  endtask

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b0;
    prec_level = '0;
    acc_in     = '0;
    shamt      = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_clr", mac_clr, 0);
    check("rst_err", err, 0);
    check("rst_data", out_data, 0);
    check("rst_lane", out_lane, 0);
    rstn = 1'b1;
    tick();

    // Full precision, single beat.
    run_drain(0, 291, 0, 0, 0, 2, 0, 1'b0);
    // Quarter precision, back to back, saturation on lane 2.
    run_drain(2, -1, 100, -200, 5, 0, 0, 1'b0);
    // Half precision with 4 stalled cycles and an ignored start while busy.
    run_drain(1, 1000, -40, 0, 0, 3, 4, 1'b1);

    // Illegal precision level.
    start      = 1'b1;
    prec_level = 2'b11;
    acc_in     = 56'h123;
    tick();
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_valid", out_valid, 0);
    check("err_busy", busy, 0);
    tick();
    check("err_once", err, 0);
    check("err_busy2", busy, 0);

    // Reset during lane 2 of a quarter drain.
    start      = 1'b1;
    prec_level = 2'(QUARTER);
    acc_in     = pack(2, 10, 20, 30, 40);
    shamt      = '0;
    tick();
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("pre_reset_lane", out_lane, 2);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_lane", out_lane, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_last", out_last, 0);
    rstn      = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_clr_after_rst", mac_clr, 0);
    end
    run_drain(2, 7, -8, 9, -10, 0, 0, 1'b0);

    // Rounding boundary: +6 and -6 shifted by 2.
    run_drain(0, 6, 0, 0, 0, 2, 0, 1'b0);
    run_drain(0, -6, 0, 0, 0, 2, 0, 1'b0);

    // Randomised words, including shifts at/above the quarter lane width.
    for (int r = 0; r < 4; r++) begin
      run_drain(2, longint'($urandom_range(16383)) - 8192,
                longint'($urandom_range(16383)) - 8192,
                longint'($urandom_range(16383)) - 8192,
                longint'($urandom_range(16383)) - 8192,
                int'($urandom_range(20)), int'($urandom_range(2)), 1'b0);
      run_drain(1, longint'($urandom_range(32'h0FFF_FFFF)) - 134217728,
                longint'($urandom_range(32'h0FFF_FFFF)) - 134217728, 0, 0,
                int'($urandom_range(40)), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
